// File: rtl/ysyx_2022040010_shift_seq.sv
// Iterative RV64 shift unit: walks a STEP-bit shifter over several cycles instead of a
// full barrel shifter. One op in flight, valid/ready on both request and result sides.
module ysyx_2022040010_shift_seq #(
   parameter int STEP = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] shift_operand,
   input  logic [63:0] shift_amount,
   input  logic [2:0]  shift_op,
   input  logic        alu_32,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] shift_result,
   output logic        busy
);

   localparam logic [6:0] STEP_W = 7'(STEP);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
   typedef enum logic [1:0] {K_NONE, K_SLL, K_SRL, K_SRA} kind_t;

   state_t      r_state;
   kind_t       r_kind;
   logic        r_w32;
   logic [63:0] r_work;
   logic [63:0] r_result;
   logic [6:0]  r_count;

   kind_t       w_kind;
   logic [6:0]  w_amt;
   logic [63:0] w_src;
   logic [6:0]  w_step;
   logic [6:0]  w_left;
   logic [63:0] w_next;
   logic        w_unused_amt;

   // Only the low 5/6 amount bits are architecturally meaningful.
   assign w_unused_amt = ^shift_amount[63:6];

   always_comb begin
      w_kind = K_NONE;
      if (shift_op[2])      w_kind = K_SLL;
      else if (shift_op[1]) w_kind = K_SRL;
      else if (shift_op[0]) w_kind = K_SRA;
   end

   assign w_amt = alu_32 ? {2'b00, shift_amount[4:0]} : {1'b0, shift_amount[5:0]};

   always_comb begin
      w_src = shift_operand;
      if (alu_32) begin
         if (w_kind == K_SRA) w_src = {{32{shift_operand[31]}}, shift_operand[31:0]};
         else                 w_src = {32'b0, shift_operand[31:0]};
      end
   end

   // One RUN step moves at most STEP positions.
   always_comb begin
      w_step = (r_count < STEP_W) ? r_count : STEP_W;
      w_left = r_count - w_step;
      case (r_kind)
         K_SLL:   w_next = r_work << w_step;
         K_SRL:   w_next = r_work >> w_step;
         K_SRA:   w_next = 64'($signed(r_work) >>> w_step);
         default: w_next = r_work;
      endcase
   end

   function automatic logic [63:0] f_result(input logic [63:0] work, input logic w32,
                                            input kind_t kind);
      if (w32)                 return {{32{work[31]}}, work[31:0]};
      else if (kind == K_NONE) return 64'b0;
      else                     return work;
   endfunction

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values; blocking here would create order-dependent simulation races.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_kind   <= K_NONE;
         r_w32    <= 1'b0;
         r_work   <= 64'b0;
         r_result <= 64'b0;
         r_count  <= 7'b0;
      end else if (flush) begin
         r_state <= ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_work  <= w_src;
                  r_count <= w_amt;
                  r_kind  <= w_kind;
                  r_w32   <= alu_32;
                  if (w_amt == 7'd0 || w_kind == K_NONE) begin
                     r_state  <= ST_DONE;
                     r_result <= f_result(w_src, alu_32, w_kind);
                  end else begin
                     r_state <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               r_work  <= w_next;
               r_count <= w_left;
               if (w_left == 7'd0) begin
                  r_state  <= ST_DONE;
                  r_result <= f_result(w_next, r_w32, r_kind);
               end
            end
            ST_DONE: begin
               if (out_ready) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign in_ready     = (r_state == ST_IDLE);
   assign out_valid    = (r_state == ST_DONE);
   assign busy         = (r_state != ST_IDLE);
   assign shift_result = r_result;

endmodule

// File: tb/tb_ysyx_2022040010_shift_seq.sv
// Scoreboard bench for the iterative shifter: RISC-V shift semantics model, directed
// corner cases, then randomized ops with random output backpressure.
module tb_ysyx_2022040010_shift_seq;

   localparam int STEP = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] shift_operand = '0;
   logic [63:0] shift_amount = '0;
   logic [2:0]  shift_op = '0;
   logic        alu_32 = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] shift_result;
   logic        busy;

   int n_tests = 0;
   int n_fail = 0;
   logic [63:0] exp_q[$];

   ysyx_2022040010_shift_seq #(.STEP(STEP)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .shift_operand(shift_operand), .shift_amount(shift_amount), .shift_op(shift_op),
      .alu_32(alu_32), .out_valid(out_valid), .out_ready(out_ready),
      .shift_result(shift_result), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, got, want);
      end
   endtask

   function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b,
                                         input logic [2:0] op, input logic w32);
      int          sh;
      logic [31:0] t;
      sh = w32 ? int'(b[4:0]) : int'(b[5:0]);
      if (w32) begin
         if (op[2])      t = a[31:0] << sh;
         else if (op[1]) t = a[31:0] >> sh;
         else if (op[0]) t = 32'($signed(a[31:0]) >>> sh);
         else            t = 32'b0;
         return {{32{t[31]}}, t};
      end
      if (op[2]) return a << sh;
      if (op[1]) return a >> sh;
      if (op[0]) return 64'($signed(a) >>> sh);
      return 64'b0;
   endfunction

   function automatic int model_lat(input logic [63:0] b, input logic [2:0] op, input logic w32);
      int amt;
      amt = w32 ? int'(b[4:0]) : int'(b[5:0]);
      if (amt == 0 || op == 3'b000) return 1;
      return 1 + (amt + STEP - 1) / STEP;
   endfunction

   // Monitor: any presented result must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL spurious_valid: got out_valid=1 required no pending op");
         end else begin
            check("result", shift_result, exp_q[0]);
            if (out_ready) void'(exp_q.pop_front());
         end
      end
   end

   task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op,
                        input logic w32);
      bit ok = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1; break; end
      end
      if (!ok) check("in_ready_timeout", {63'b0, in_ready}, 64'd1);
      shift_operand = a;
      shift_amount  = b;
      shift_op      = op;
      alu_32        = w32;
      in_valid      = 1'b1;
      @(posedge clk);
      exp_q.push_back(model(a, b, op, w32));
      #1;
      in_valid      = 1'b0;
      shift_operand = {$urandom, $urandom};
      shift_amount  = {$urandom, $urandom};
      shift_op      = 3'($urandom);
      alu_32        = 1'($urandom);
   endtask

   task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op,
                         input logic w32, input int hold);
      int n = 0;
      out_ready = (hold == 0);
      issue(a, b, op, w32);
      while (1) begin
         @(negedge clk);
         n++;
         if (out_valid || n > 100) break;
      end
      check("latency", 64'(n), 64'(model_lat(b, op, w32)));
      check("done_in_ready", {63'b0, in_ready}, 64'd0);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         check("stall_valid", {62'b0, out_valid, in_ready}, 64'd2);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("idle_after", {61'b0, in_ready, out_valid, busy}, 64'd4);
      out_ready = 1'b0;
   endtask

   initial begin
      logic [63:0] amts[9];
      logic [2:0]  op;
      logic        w32;
      logic [63:0] b;

      #3;
      check("reset_state", {61'b0, in_ready, out_valid, busy}, 64'd4);
      @(negedge clk);
      rst_n = 1'b1;

      run_op(64'h1, 64'd63, 3'b100, 1'b0, 0);
      run_op(64'h0000_0000_8000_0000, 64'd4, 3'b001, 1'b1, 0);
      run_op(64'hFFFF_FFFF_FFFF_FFF0, 64'h25, 3'b010, 1'b1, 0);
      run_op(64'h1234, 64'd0, 3'b010, 1'b0, 5);

      // Flush in the middle of a long SLL: op is dropped, no result appears.
      issue(64'hDEAD_BEEF_0000_0001, 64'd40, 3'b100, 1'b0);
      @(posedge clk); #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_idle", {61'b0, in_ready, out_valid, busy}, 64'd4);
      void'(exp_q.pop_back());
      repeat (8) @(negedge clk);
      run_op(64'h8000_0000_0000_0000, 64'd63, 3'b001, 1'b0, 0);

      // Asynchronous reset during RUN, observed before any further clock edge.
      issue(64'h5, 64'd40, 3'b100, 1'b0);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      check("async_reset", {61'b0, in_ready, out_valid, busy}, 64'd4);
      void'(exp_q.pop_back());
      @(negedge clk);
      rst_n = 1'b1;
      run_op(64'h3, 64'd1, 3'b100, 1'b0, 0);

      amts = '{64'd0, 64'd1, 64'(STEP - 1), 64'(STEP), 64'(STEP + 1), 64'd31, 64'd32, 64'd63,
               64'hFFFF_FFFF_FFFF_FFC0};
      for (int i = 0; i < 60; i++) begin
         w32 = 1'($urandom);
         case ($urandom_range(0, 3))
            0:       op = 3'b100;
            1:       op = 3'b010;
            2:       op = 3'b001;
            default: op = w32 ? 3'(3'b100 | 3'($urandom)) : 3'($urandom);
         endcase
         if ($urandom_range(0, 1) == 1) b = amts[$urandom_range(0, 8)] | {$urandom, 26'b0, 6'b0} & ~64'h3F;
         else                           b = {$urandom, $urandom};
         run_op({$urandom, $urandom}, b, op, w32, $urandom_range(0, 3));
      end

      repeat (4) @(negedge clk);
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ysyx_2022040010_shift_seq.md
Name: ysyx_2022040010_shift_seq

Overview:
Iterative, area-reduced shift unit for the EXU. It sequences a narrow STEP-bit shifter over multiple cycles instead of using a full 64-bit barrel shifter. It accepts one shift op at a time over a valid/ready handshake and returns the result over a second valid/ready handshake. It supports RV64 SLL/SRL/SRA and their 32-bit W forms, with the same op encoding as the single-cycle shifter.

Parameters:
STEP, 8, maximum bit positions shifted per RUN cycle; must be a power of two, 1..64.

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous kill of any in-flight op (pipeline redirect)
in_valid  input  1  request valid
in_ready  output  1  unit can accept a request
shift_operand  input  64  src1
shift_amount  input  64  src2; only the low 6 bits (alu_32=0) or low 5 bits (alu_32=1) are used
shift_op  input  3  [2]=SLL, [1]=SRL, [0]=SRA; priority [2]>[1]>[0]
alu_32  input  1  W-form op
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
shift_result  output  64  result
busy  output  1  high in RUN or DONE

Behaviour:
- Reset: rst_n=0 forces state=IDLE, work/result/count regs=0, out_valid=0, busy=0, in_ready=1. Reset takes effect immediately, including mid-op.
- States: IDLE, RUN, DONE. in_ready=(state==IDLE). out_valid=(state==DONE). busy=(state!=IDLE).
- Accept: in IDLE with in_valid=1 and flush=0 at a rising edge, the unit latches the op.
  - amt = alu_32 ? shift_amount[4:0] : shift_amount[5:0].
  - work = 64-bit source.
    - alu_32=0: work = shift_operand.
    - alu_32=1, SRA: work = sign-extended bit 31 of shift_operand.
    - alu_32=1, any other op: work = zero-extended low 32 bits of shift_operand.
  - Decoded kind: SLL if op[2]; else SRL if op[1]; else SRA if op[0]; else NONE.
- Next state after accept: DONE if amt==0 or kind==NONE; otherwise RUN with remaining=amt.
- RUN, each cycle:
  - s = min(remaining, STEP).
  - SLL: work <<= s, zero fill. SRL: work >>= s, zero fill. SRA: work >>= s, filling with work[63].
  - remaining -= s. When remaining reaches 0 at this edge, go to DONE.
- Result: loaded into the result reg on entry to DONE.
  - alu_32=1: {32{work[31]}, work[31:0]}.
  - kind==NONE: 0.
  - Otherwise: work.
- Latency: with the handshake at cycle k, out_valid is high from cycle k+1+ceil(amt/STEP). For STEP=8: amt=0 → k+1; amt=63 → k+9.
- DONE:
  - shift_result and out_valid are held stable until out_ready=1.
  - out_valid&out_ready → IDLE next cycle. in_ready is not asserted in DONE, so there is no same-cycle re-accept; throughput is one op per 2+ceil(amt/STEP) cycles.
- flush=1 (any state): next state=IDLE, the op is dropped, and out_valid deasserts next cycle.
  - flush with in_valid in IDLE: the request is not accepted.
  - flush with out_ready in DONE: treated as consumed.
- shift_result is don't-care (holds its last value) outside DONE. The bench checks it only when out_valid=1.
- Inputs other than handshakes are sampled only at the accept edge; later input changes do not affect the in-flight op.

Test Plan:
- SLL 64-bit, operand=0x1, amt=63, op=100, alu_32=0, out_ready=1 → out_valid at k+9, result=0x8000_0000_0000_0000, in_ready=1 at k+10.
- SRAW, operand=0x0000_0000_8000_0000, amt=4, op=001, alu_32=1 → out_valid at k+2, result=0xFFFF_FFFF_F800_0000.
- SRLW, operand=0xFFFF_FFFF_FFFF_FFF0, shift_amount=0x25 (masked to 5), op=010, alu_32=1 → result=0x0000_0000_07FF_FFFF at k+2.
- Backpressure and zero shift: amt=0, op=010, operand=0x1234 → out_valid at k+1; hold out_ready=0 for 5 cycles → out_valid=1, result=0x1234, in_ready=0 throughout; out_ready=1 → IDLE and in_ready=1 next cycle.
- Flush mid-RUN: SLL amt=40 accepted, flush at k+2 → out_valid never asserts, in_ready=1 at k+3; then SRA 64-bit operand=0x8000_0000_0000_0000, amt=63 → result=0xFFFF_FFFF_FFFF_FFFF at handshake+9.
- Reset mid-op: assert rst_n=0 asynchronously during RUN → in_ready=1, out_valid=0, busy=0 with no clock edge; after release, a new SLL operand=0x3, amt=1 → result=0x6 at k+2.
